// File: rtl/acquisition_sequencer.sv
// Sequences one acquisition per PC request, then streams num_samples samples (oldest first) from the circular sample RAM.
// Latency: start 1 cycle after request; 3 cycles/sample with tx_ready high; buf_ack 1 cycle after the last handshake.
// Backpressure: SEND holds tx_data/rd_addr while tx_ready is low; cmd_stop aborts to ACK (or IDLE before readout).
module acquisition_sequencer #(
  parameter int BITS_ADC  = 8,
  parameter int ADDR_BITS = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_request,
  input  logic                 cmd_stop,
  input  logic [15:0]          num_samples,
  output logic                 start,
  input  logic                 buf_rdy,
  output logic                 buf_ack,
  input  logic [ADDR_BITS-1:0] wr_addr,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [BITS_ADC-1:0]  rd_data,
  output logic [BITS_ADC-1:0]  tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [2:0] {
    IDLE, ARM, WAIT_BUF, READ, LATCH, SEND, ACK
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] n_lat;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic        aborted;

  assign cnt_inc = cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      n_lat   <= '0;
      cnt     <= '0;
      aborted <= 1'b0;
      rd_addr <= '0;
      tx_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cmd_request && !cmd_stop) begin
            n_lat   <= num_samples;
            aborted <= 1'b0;
          end
        end
        WAIT_BUF: begin
          // Oldest sample sits n_lat entries behind the write pointer.
          if (buf_rdy && !cmd_stop) begin
            rd_addr <= wr_addr - n_lat[ADDR_BITS-1:0];
            cnt     <= '0;
          end
        end
        READ: begin
          if (cmd_stop) aborted <= 1'b1;
        end
        LATCH: begin
          if (cmd_stop) aborted <= 1'b1;
          else          tx_data <= rd_data;
        end
        SEND: begin
          if (cmd_stop) begin
            aborted <= 1'b1;
          end else if (tx_ready) begin
            rd_addr <= rd_addr + ADDR_BITS'(1);
            cnt     <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (cmd_request && !cmd_stop) state_nxt = ARM;
      ARM:      state_nxt = cmd_stop ? IDLE : WAIT_BUF;
      WAIT_BUF: begin
        if (cmd_stop)     state_nxt = IDLE;
        else if (buf_rdy) state_nxt = (n_lat == 16'd0) ? ACK : READ;
      end
      READ:     state_nxt = cmd_stop ? ACK : LATCH;
      LATCH:    state_nxt = cmd_stop ? ACK : SEND;
      SEND: begin
        if (cmd_stop)      state_nxt = ACK;
        else if (tx_ready) state_nxt = (cnt_inc == n_lat) ? ACK : READ;
      end
      ACK:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign start      = (state == ARM);
  assign rd_en      = (state == READ);
  assign tx_valid   = (state == SEND);
  assign buf_ack    = (state == ACK);
  assign busy       = (state != IDLE);
  assign frame_done = (state == ACK) && !aborted;

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Randomized bench for acquisition_sequencer: a monitor collects reads and handshakes,
// and each frame is compared with addresses/data computed from the circular-buffer rule.
module tb_acquisition_sequencer;
  localparam int AB = 15;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, cmd_request, cmd_stop, buf_rdy, tx_ready;
  logic [15:0]   num_samples;
  logic [AB-1:0] wr_addr, rd_addr;
  logic [DW-1:0] rd_data, tx_data;
  logic          start, buf_ack, rd_en, tx_valid, busy, frame_done;

  acquisition_sequencer #(.BITS_ADC(DW), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .cmd_request(cmd_request), .cmd_stop(cmd_stop),
    .num_samples(num_samples), .start(start), .buf_rdy(buf_rdy), .buf_ack(buf_ack),
    .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:(1<<AB)-1];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Oldest-first address of sample k for a frame of n samples ending at write pointer wa.
  function automatic logic [AB-1:0] exp_addr(input logic [AB-1:0] wa, input logic [15:0] n, input int k);
    int a;
    a = (int'(wa) - (int'(n) % 32768) + k + 65536) % 32768;
    return AB'(a);
  endfunction

  // Monitor: everything observed at the falling edge.
  int            rd_q[$];
  logic [DW-1:0] tx_q[$];
  int starts = 0, acks = 0, dones = 0, vcyc = 0;
  initial begin
    logic          prev_stall, prev_stop;
    logic [DW-1:0] prev_data;
    logic [AB-1:0] prev_addr;
    prev_stall = 1'b0; prev_stop = 1'b0; prev_data = '0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (start) starts++;
      if (buf_ack) acks++;
      if (buf_ack && frame_done) dones++;
      if (tx_valid) vcyc++;
      if (rd_en) rd_q.push_back(int'(rd_addr));
      if (tx_valid && tx_ready && !cmd_stop && !rst) tx_q.push_back(tx_data);
      if (prev_stall && !prev_stop) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, prev_data);
        chk("stall_addr", rd_addr, prev_addr);
        chk("stall_rden", rd_en, 0);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_stop  = cmd_stop || rst;
      prev_data  = tx_data;
      prev_addr  = rd_addr;
    end
  end

  // tx_ready driver: 0 = high, 1 = random, 2 = 10-cycle stall on sample 2, 3 = low.
  int ready_mode = 0;
  int hs_base = 0;
  initial begin
    int stalled;
    stalled = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        1: tx_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (tx_valid && (tx_q.size() - hs_base) == 1 && stalled < 10) begin
            tx_ready = 1'b0;
            stalled++;
          end else begin
            tx_ready = 1'b1;
          end
        end
        3: tx_ready = 1'b0;
        default: begin
          tx_ready = 1'b1;
          stalled = 0;
        end
      endcase
    end
  end

  task automatic req_to_waitbuf(input logic [AB-1:0] wa, input logic [15:0] n);
    @(posedge clk); #1;
    wr_addr = wa; num_samples = n; cmd_request = 1'b1;
    @(posedge clk); #1 cmd_request = 1'b0;
    @(posedge clk); #1;
  endtask

  // extra < 0 skips the cycle-count check.
  task automatic run_frame(input logic [AB-1:0] wa, input logic [15:0] n, input int mode, input int extra);
    int s0, a0, d0, r0, t0, v0, cyc, budget;
    s0 = starts; a0 = acks; d0 = dones; r0 = rd_q.size(); t0 = tx_q.size(); v0 = vcyc;
    hs_base = t0;
    ready_mode = mode;
    @(posedge clk); #1;
    wr_addr = wa; num_samples = n; cmd_request = 1'b1;
    @(posedge clk); #1;
    cmd_request = 1'b0; num_samples = 16'($urandom);
    @(negedge clk);
    chk("start", start, 1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(posedge clk); #1 buf_rdy = 1'b1;
    @(posedge clk); #1 buf_rdy = 1'b0; wr_addr = AB'($urandom);
    @(negedge clk);
    if (n == 0) chk("ack_first", buf_ack, 1);
    else        chk("rden_first", rd_en, 1);
    cyc = 1;
    budget = 40 * int'(n) + 40;
    while (!buf_ack && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!buf_ack) begin
      chk("ack_timeout", 0, 1);
    end else begin
      if (extra >= 0) chk("cycles", cyc, 3 * int'(n) + 1 + extra);
      chk("frame_done", frame_done, 1);
    end
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("starts", starts - s0, 1);
    chk("acks", acks - a0, 1);
    chk("dones", dones - d0, 1);
    chk("nreads", rd_q.size() - r0, n);
    chk("nsent", tx_q.size() - t0, n);
    for (int k = 0; k < int'(n); k++) begin
      if (r0 + k < rd_q.size()) chk("rd_addr", rd_q[r0 + k], exp_addr(wa, n, k));
      if (t0 + k < tx_q.size()) chk("tx_data", tx_q[t0 + k], ram[exp_addr(wa, n, k)]);
    end
    if (n == 0) chk("no_valid", vcyc - v0, 0);
    ready_mode = 0;
  endtask

  task automatic abort_in_send(input logic [AB-1:0] wa);
    int s0, a0, d0, t0, guard;
    s0 = starts; a0 = acks; d0 = dones; t0 = tx_q.size();
    req_to_waitbuf(wa, 16'd4);
    buf_rdy = 1'b1;
    @(posedge clk); #1 buf_rdy = 1'b0; cmd_request = 1'b1;
    @(posedge clk); #1 cmd_request = 1'b0;
    guard = 0;
    while (!(tx_valid && (tx_q.size() - t0) == 2) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("abort_reach", guard < 50, 1);
    ready_mode = 3;
    cmd_stop = 1'b1;
    @(posedge clk); #1 cmd_stop = 1'b0; ready_mode = 0;
    @(negedge clk);
    chk("abort_ack", buf_ack, 1);
    chk("abort_done", frame_done, 0);
    chk("abort_valid", tx_valid, 0);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_starts", starts - s0, 1);
    chk("abort_acks", acks - a0, 1);
    chk("abort_dones", dones - d0, 0);
    chk("abort_nsent", tx_q.size() - t0, 2);
    for (int k = 0; k < 2; k++)
      if (t0 + k < tx_q.size()) chk("abort_data", tx_q[t0 + k], ram[exp_addr(wa, 16'd4, k)]);
  endtask

  initial begin
    int a0, r0;
    if ($urandom_range(0, 1) > 1) $display("unreachable");
    for (int a = 0; a < (1 << AB); a++) ram[a] = DW'(a);
    rst = 1'b1; cmd_request = 1'b0; cmd_stop = 1'b0; buf_rdy = 1'b0;
    num_samples = '0; wr_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {start, buf_ack, rd_en, tx_valid, busy, frame_done}, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_data", tx_data, 0);
    @(posedge clk); #1 rst = 1'b0;

    run_frame(15'h0010, 16'd4, 0, 0);
    r0 = rd_q.size();
    run_frame(15'h0002, 16'd4, 0, 0);
    if (rd_q.size() >= r0 + 4) begin
      chk("wrap0", rd_q[r0], 15'h7FFE);
      chk("wrap3", rd_q[r0 + 3], 15'h0001);
    end else begin
      chk("wrap_reads", rd_q.size() - r0, 4);
    end
    run_frame(15'h0100, 16'd4, 2, 10);
    run_frame(15'h1234, 16'd0, 0, 0);

    abort_in_send(15'h0200);

    a0 = acks;
    req_to_waitbuf(15'h0300, 16'd4);
    cmd_stop = 1'b1; buf_rdy = 1'b1;
    @(posedge clk); #1 cmd_stop = 1'b0; buf_rdy = 1'b0;
    @(negedge clk);
    chk("wb_stop_busy", busy, 0);
    chk("wb_stop_rden", rd_en, 0);
    repeat (3) @(negedge clk);
    chk("wb_stop_acks", acks - a0, 0);

    @(posedge clk); #1 cmd_request = 1'b1; cmd_stop = 1'b1;
    @(posedge clk); #1 cmd_request = 1'b0; cmd_stop = 1'b0;
    @(negedge clk);
    chk("idle_stop", {start, busy}, 0);

    a0 = acks;
    req_to_waitbuf(15'h0456, 16'd4);
    buf_rdy = 1'b1;
    @(posedge clk); #1 buf_rdy = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("latch_rst_outs", {start, buf_ack, rd_en, tx_valid, busy, frame_done}, 0);
    chk("latch_rst_addr", rd_addr, 0);
    chk("latch_rst_data", tx_data, 0);
    repeat (2) @(negedge clk);
    chk("latch_rst_acks", acks - a0, 0);
    run_frame(15'h0040, 16'd4, 0, 0);

    for (int a = 0; a < (1 << AB); a++) ram[a] = DW'($urandom);
    for (int f = 0; f < 40; f++) begin
      if (f % 5 == 0) run_frame(AB'($urandom_range(0, 6)), 16'($urandom_range(1, 12)), 1, -1);
      else            run_frame(AB'($urandom), 16'($urandom_range(0, 24)), 1, -1);
    end
    run_frame(AB'($urandom), 16'd9, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/acquisition_sequencer.md
# acquisition_sequencer

Sequences one oscilloscope acquisition per PC request and owns the sample RAM read port during readout. On a PC request it pulses `start` to the buffer controller and waits for `send_data_rdy`. It then reads `num_samples` samples from the circular sample RAM, oldest first, and streams them to the PC-communication transmitter over a valid/ready handshake. When the readout finishes it acknowledges the buffer controller so acquisition resumes.

## Interface
- `BITS_ADC`, 8, sample width
- `ADDR_BITS`, 15, sample RAM address width (depth 2^ADDR_BITS)

- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `cmd_request`  in  1  one-cycle pulse from the PC command decoder: acquire one frame
- `cmd_stop`  in  1  one-cycle pulse: abort current frame
- `num_samples`  in  16  frame length; sampled on an accepted `cmd_request`
- `start`  out  1  one-cycle pulse to the buffer controller
- `buf_rdy`  in  1  buffer controller's `send_data_rdy`
- `buf_ack`  out  1  one-cycle pulse to the buffer controller's `send_data_ack`
- `wr_addr`  in  ADDR_BITS  RAM write pointer: the next address to be written
- `rd_en`  out  1  RAM read strobe
- `rd_addr`  out  ADDR_BITS  RAM read address
- `rd_data`  in  BITS_ADC  RAM read data, valid the cycle after `rd_en`
- `tx_data`  out  BITS_ADC  sample to the transmitter
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  transmitter accepts `tx_data`
- `busy`  out  1  high in every state except IDLE
- `frame_done`  out  1  one-cycle pulse on completion of a non-aborted frame

## Operation
- Moore FSM with states IDLE, ARM, WAIT_BUF, READ, LATCH, SEND, ACK.
- Output decode:
  - `start` = ARM
  - `rd_en` = READ
  - `tx_valid` = SEND
  - `buf_ack` = ACK
  - `busy` = not IDLE
  - `frame_done` = ACK and not aborted
- IDLE: on `cmd_request`, latch `num_samples` into `n_lat`, clear the abort flag, go to ARM. A `cmd_request` outside IDLE is ignored.
- ARM: go to WAIT_BUF unconditionally.
- WAIT_BUF: on `buf_rdy`=1:
  - set `rd_addr` <= (`wr_addr` - `n_lat`) mod 2^ADDR_BITS, using the low ADDR_BITS bits of `n_lat`;
  - clear the sample counter `cnt` (16 bit);
  - go to ACK if `n_lat`==0, else to READ.
- READ: go to LATCH.
- LATCH: `tx_data` <= `rd_data`; go to SEND.
- SEND: hold `tx_data` stable. On `tx_ready`:
  - `rd_addr` <= `rd_addr`+1 (wraps 2^ADDR_BITS-1 to 0);
  - `cnt` <= `cnt`+1;
  - go to ACK if `cnt`+1==`n_lat`, else to READ.
- ACK: go to IDLE.
- `n_lat` > 2^ADDR_BITS is not clamped. Addresses keep wrapping, so samples repeat.
- `cmd_stop` has priority over all other transitions in the same cycle:
  - in IDLE: ignored, and a simultaneous `cmd_request` is dropped;
  - in ARM or WAIT_BUF: go to IDLE, no `buf_ack`;
  - in READ, LATCH or SEND: set the abort flag, go to ACK, so `buf_ack` pulses and `frame_done` stays 0;
  - in ACK: ignored, and the abort flag is unchanged.
- A sample in LATCH or SEND that has not been accepted is discarded on abort.

## Timing
- Reset: state IDLE; all outputs 0; `rd_addr`, `tx_data`, `cnt`, `n_lat` and the abort flag all 0. Reset mid-frame returns to IDLE on the next edge with no `buf_ack`.
- `cmd_request` sampled at edge k gives `start`=1 during cycle k+1 (exactly one cycle).
- `buf_rdy` sampled at edge k gives `rd_en`=1 during cycle k+1. With `n_lat`=0, `buf_ack` is 1 during cycle k+1 instead.
- Per sample: READ (1 cycle), LATCH (1 cycle), SEND (≥1 cycle). Minimum 3 cycles/sample with `tx_ready` held high.
- The last SEND handshake at edge j gives `buf_ack`=`frame_done`=1 during cycle j+1 and `busy`=0 from cycle j+2.
- While `tx_valid`=1 and `tx_ready`=0: `tx_data` and `rd_addr` are stable and `rd_en`=0.
- `buf_rdy` is only sampled in WAIT_BUF. `buf_rdy` still high during ACK is ignored.

## Test plan
1. `wr_addr`=0x0010, `num_samples`=4, RAM[a]=a[7:0], `tx_ready`=1 → one `start` pulse; reads 0x000C–0x000F; `tx_data` 0x0C,0x0D,0x0E,0x0F; then one `buf_ack` and one `frame_done`; 3 cycles/sample.
2. Wrap: `wr_addr`=0x0002, `num_samples`=4 → `rd_addr` 0x7FFE,0x7FFF,0x0000,0x0001 in order.
3. Backpressure: `tx_ready` low for 10 cycles on sample 2 → `tx_valid` held, `tx_data` unchanged, no `rd_en`; the stream resumes correctly.
4. `num_samples`=0 → `start`, then `buf_ack`+`frame_done` one cycle after `buf_rdy` seen; no `rd_en`, no `tx_valid`.
5. `cmd_stop` in SEND after 2 of 4 samples accepted → next cycle `buf_ack`=1, `frame_done`=0, `tx_valid`=0, then IDLE. A `cmd_request` during the frame produces no second `start`. `cmd_stop` in WAIT_BUF → IDLE with no `buf_ack`.
6. `rst` asserted in LATCH → all outputs 0 after the next edge. A fresh `cmd_request` then completes a normal 4-sample frame.
